// File: rtl/bit_pattern_generator.sv
// Builds a WIDTH-bit thermometer pattern with N ones at the LSBs, shifting in
// one '1' per clock. Start/done handshake; N above WIDTH saturates and flags err.
module bit_pattern_generator #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CW-1:0]    count_in,
    output logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_BUILD = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] WMAX = CW'(WIDTH);

    logic [1:0]    state;
    logic [CW-1:0] target;
    logic [CW-1:0] ones;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pattern <= '0;
            err     <= 1'b0;
            target  <= '0;
            ones    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target  <= (count_in > WMAX) ? WMAX : count_in;
                        err     <= (count_in > WMAX);
                        pattern <= '0;
                        ones    <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_BUILD;
                S_BUILD: begin
                    // one cycle spent on the final compare, so done lands at k+2+N
                    if (ones == target) begin
                        state <= S_DONE;
                    end else begin
                        pattern <= {pattern[WIDTH-2:0], 1'b1};
                        ones    <= ones + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_LOAD) || (state == S_BUILD);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_bit_pattern_generator.sv
// Self-checking bench for bit_pattern_generator: directed scenarios plus a
// shuffled N=0..15 sweep against a thermometer/popcount reference model.
module tb_bit_pattern_generator;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] count_in;
    logic [7:0] pattern;
    logic       busy;
    logic       done;
    logic       err;

    int checks;
    int failures;

    bit_pattern_generator #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .count_in (count_in),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nsat(input int n);
        return (n > 8) ? 8 : n;
    endfunction

    function automatic logic [7:0] exp_pat(input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < nsat(n); i++) r[i] = 1'b1;
        return r;
    endfunction

    // Leaves the bench at the negedge following the accepting edge k.
    task automatic launch(input int n);
        @(negedge clk);
        count_in = 4'(n);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // cyc = number of edges after k at which done is first seen.
    task automatic wait_done(output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        while (!done && cyc < 40) begin
            if (busy) bcyc++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL timeout: done not seen within %0d cycles", cyc);
        end
    endtask

    task automatic check_result(input string name, input int n, input int cyc);
        checks++;
        if (cyc !== 2 + nsat(n)) begin
            failures++;
            $display("FAIL %s latency N=%0d: got %0d edges, want %0d", name, n, cyc, 2 + nsat(n));
        end
        checks++;
        if (pattern !== exp_pat(n)) begin
            failures++;
            $display("FAIL %s pattern N=%0d: got %h, want %h", name, n, pattern, exp_pat(n));
        end
        checks++;
        if ($countones(pattern) != nsat(n)) begin
            failures++;
            $display("FAIL %s popcount N=%0d: got %0d, want %0d", name, n, $countones(pattern), nsat(n));
        end
        checks++;
        if (err !== (n > 8)) begin
            failures++;
            $display("FAIL %s err N=%0d: got %b, want %b", name, n, err, (n > 8));
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy with done N=%0d: got %b, want 0", name, n, busy);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        count_in = '0;
        #2;
        checks++;
        if ({pattern, busy, done, err} !== 11'b0) begin
            failures++;
            $display("FAIL reset: got pattern=%h busy=%b done=%b err=%b, want all 0", pattern, busy, done, err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({pattern, busy, done, err} !== 11'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got pattern=%h busy=%b done=%b err=%b, want all 0", pattern, busy, done, err);
        end
    endtask

    task automatic test_basic();
        int cyc, bcyc;
        launch(3);
        wait_done(cyc, bcyc);
        check_result("n3", 3, cyc);
        checks++;
        if (bcyc !== 5) begin
            failures++;
            $display("FAIL n3 busy cycles: got %0d, want 5", bcyc);
        end
    endtask

    task automatic test_boundaries();
        int cyc, bcyc;
        launch(0);
        wait_done(cyc, bcyc);
        check_result("n0", 0, cyc);
        launch(8);
        wait_done(cyc, bcyc);
        check_result("n8", 8, cyc);
        launch(12);
        wait_done(cyc, bcyc);
        check_result("n12", 12, cyc);
    endtask

    task automatic test_held_start();
        int cyc, bcyc;
        @(negedge clk);
        count_in = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        // changing count_in mid-build must not alter the running target
        count_in = 4'd2;
        wait_done(cyc, bcyc);
        check_result("held", 5, cyc);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || pattern !== 8'h00) begin
            failures++;
            $display("FAIL relaunch: got done=%b busy=%b pattern=%h, want done=0 busy=1 pattern=00", done, busy, pattern);
        end
        start = 1'b0;
        wait_done(cyc, bcyc);
        check_result("relaunch", 2, cyc);
    endtask

    task automatic test_async_reset();
        int cyc, bcyc;
        launch(6);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pattern, busy, done, err} !== 11'b0) begin
            failures++;
            $display("FAIL async_reset: got pattern=%h busy=%b done=%b err=%b, want all 0", pattern, busy, done, err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        launch(2);
        wait_done(cyc, bcyc);
        check_result("after_reset", 2, cyc);
    endtask

    task automatic test_sweep();
        int order[16];
        int cyc, bcyc, tmp, j, gap;
        logic [7:0] held;
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            launch(order[i]);
            wait_done(cyc, bcyc);
            check_result("sweep", order[i], cyc);
            held = exp_pat(order[i]);
            gap  = int'($urandom_range(3, 0));
            count_in = 4'($urandom);
            repeat (gap) @(negedge clk);
            checks++;
            if (pattern !== held || done !== 1'b1) begin
                failures++;
                $display("FAIL hold N=%0d: got pattern=%h done=%b, want %h done=1", order[i], pattern, done, held);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_held_start();
        test_async_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
